// File: rtl/gate_bist.sv
// gate_bist: exhaustive built-in self test for a small combinational gate.
// Every input vector is applied in turn. After SETTLE wait cycles the gate
// response is compared against the expected truth table. The block counts
// mismatches and records the first failing vector.
module gate_bist #(
   parameter int unsigned           N_IN   = 1,
   parameter logic [2**N_IN-1:0]    TRUTH  = 2'b01,
   parameter int unsigned           SETTLE = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic [N_IN-1:0] stim,
   input  logic            resp,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [7:0]      err_count,
   output logic            fail_valid,
   output logic [N_IN-1:0] fail_vec
);

   typedef enum logic [1:0] {IDLE, WAIT, CHECK, FINISH} state_t;

   localparam logic [N_IN-1:0] LAST_VEC    = '1;
   localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

   state_t          state;
   state_t          state_next;
   logic [3:0]      wait_cnt;
   logic            mismatch;

   // The error counter holds at 255 instead of wrapping back to 0.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic and the per-vector compare
   always_comb begin
      state_next = state;
      mismatch   = (state == CHECK) && (resp != TRUTH[stim]);
      case (state)
         IDLE:    if (start) state_next = WAIT;
         WAIT:    if (wait_cnt == SETTLE_LAST) state_next = CHECK;
         CHECK:   state_next = (stim == LAST_VEC) ? FINISH : WAIT;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Stimulus, wait counter and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         stim       <= '0;
         wait_cnt   <= '0;
         err_count  <= '0;
         fail_valid <= 1'b0;
         fail_vec   <= '0;
         pass       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  stim       <= '0;
                  wait_cnt   <= '0;
                  err_count  <= '0;
                  fail_valid <= 1'b0;
                  fail_vec   <= '0;
                  pass       <= 1'b0;
               end
            end
            WAIT: begin
               wait_cnt <= wait_cnt + 4'd1;
            end
            CHECK: begin
               if (mismatch) begin
                  err_count <= sat_inc(err_count);
                  if (!fail_valid) begin
                     fail_valid <= 1'b1;
                     fail_vec   <= stim;
                  end
               end
               if (stim != LAST_VEC) begin
                  stim     <= stim + N_IN'(1);
                  wait_cnt <= '0;
               end else begin
                  // The verdict includes this final compare. It is therefore
                  // already valid in the FINISH (done) cycle.
                  pass <= (err_count == 8'd0) && !mismatch;
               end
            end
            default: ;
         endcase
      end
   end

   // Status decoded from the state
   always_comb begin
      busy = (state != IDLE);
      done = (state == FINISH);
   end

endmodule

// File: doc/gate_bist.md
GATE_BIST -- requirements
Module: gate_bist

Interface
REQ-001 Parameter N_IN, default 1: input width of the combinational gate under test, legal range 1..4.
REQ-002 Parameter TRUTH, default 2'b01, width 2**N_IN: expected gate output; bit k is the expected response to input vector k.
REQ-003 Parameter SETTLE, default 2: wait cycles between applying a vector and sampling the response, legal range 1..15.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port start, input, 1: request one exhaustive test run; sampled only in IDLE.
REQ-007 Port stim, output, N_IN: registered input vector driven to the gate under test.
REQ-008 Port resp, input, 1: gate under test output; combinational response to stim.
REQ-009 Port busy, output, 1: high while a run is in progress (WAIT, CHECK, FINISH).
REQ-010 Port done, output, 1: single-cycle pulse marking run completion.
REQ-011 Port pass, output, 1: run result; valid from the done cycle until the next accepted start.
REQ-012 Port err_count, output, 8: number of mismatching vectors in the current or last run.
REQ-013 Port fail_valid, output, 1: high once any mismatch has been recorded in the run.
REQ-014 Port fail_vec, output, N_IN: first mismatching vector; meaningful only when fail_valid=1.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, WAIT, CHECK, FINISH.
REQ-016 IDLE: if start=1, the block SHALL go to WAIT, set stim=0, clear the wait counter, and clear err_count, fail_valid, fail_vec and pass; otherwise it SHALL stay in IDLE and hold all outputs.
REQ-017 WAIT: the wait counter SHALL increment each cycle; the FSM SHALL move to CHECK after exactly SETTLE cycles in WAIT.
REQ-018 CHECK (one cycle): if resp != TRUTH[stim], err_count SHALL increment, saturating at 255.
REQ-019 CHECK: on the first mismatch of a run, fail_vec SHALL capture stim and fail_valid SHALL set; later mismatches SHALL NOT overwrite fail_vec.
REQ-020 CHECK with stim < 2**N_IN-1: the FSM SHALL increment stim, clear the wait counter and return to WAIT.
REQ-021 CHECK with stim = 2**N_IN-1: the FSM SHALL go to FINISH and hold stim; no wrap to 0.
REQ-022 FINISH (one cycle): done SHALL be 1, and pass SHALL be registered as 1 only if err_count=0, including the final CHECK result; the FSM SHALL then return to IDLE.
REQ-023 Latency: done SHALL assert exactly 2**N_IN*(SETTLE+1)+1 cycles after the edge that samples start.
REQ-024 start SHALL be ignored in WAIT, CHECK and FINISH; a start held high through the return to IDLE SHALL launch a new run in the first IDLE cycle.
REQ-025 busy SHALL be 0 in IDLE and 1 in all other states; done SHALL be 0 outside FINISH.

Reset
REQ-026 reset=1 at a rising edge SHALL force IDLE and set stim=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0, wait counter=0.
REQ-027 reset SHALL take priority over start and over every state transition, including mid-run; an aborted run SHALL NOT pulse done.

Verification
REQ-028 Reset check: assert reset for 2 cycles with start=1 -> all outputs 0 and busy stays 0 while reset is high.
REQ-029 Good NOT gate, with N_IN=1, TRUTH=2'b01, SETTLE=2 and resp=~stim[0]: pulse start -> stim goes 0 then 1, done pulses 7 cycles after start, pass=1, err_count=0, fail_valid=0.
REQ-030 Stuck-at-0 NOT gate, with the same parameters and resp=0: run -> err_count=1, fail_valid=1, fail_vec=0, pass=0.
REQ-031 Stuck-at-1 AND2, with N_IN=2, TRUTH=4'b1000, SETTLE=1 and resp=1: run -> done 9 cycles after start, err_count=3, fail_vec=2'b00, pass=0.
REQ-032 Mid-run reset and busy start, with N_IN=2: assert start during WAIT -> no effect; assert reset during CHECK of vector 2 -> IDLE next cycle, err_count=0, no done pulse.
REQ-033 Back-to-back runs: after a failing run, hold start high through done -> new run starts in the IDLE cycle, err_count and fail_valid clear, and a good gate yields pass=1.
